// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } trap_state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [1:0] LOAD_SRC_DEF = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding source select for one E-stage operand; M stage wins over W stage.
module hazard_ctrl_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   output logic [1:0]        sel
);

   // x0 is never forwarded; the newest producer (M) takes precedence
   always_comb begin
      sel = FWD_RF;
      if (rs != '0) begin
         if (reg_write_m && (rd_m == rs))
            sel = FWD_M;
         else if (reg_write_w && (rd_w == rs))
            sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use / long-op / CSR stalls,
// long-latency scoreboard and trap drain-and-flush sequencing.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | normal operation, TrapReq sampled here
// ST_DRAIN | trap pending, front end held until the long op retires
// ST_FLUSH | single cycle: flush D/E/M and redirect PC to trap target
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int         REG_AW   = 5,
   parameter int         LONG_LAT = 8,
   parameter int         CNT_W    = 4,
   parameter logic [1:0] LOAD_SRC = LOAD_SRC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] RdD,
   input  logic              UseRs1D,
   input  logic              UseRs2D,
   input  logic              RegWriteD,
   input  logic              LongOpD,
   input  logic              CsrD,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [1:0]        ResultSrcE,
   input  logic              LongOpE,
   input  logic              CsrWrE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              CsrWrM,
   input  logic              PCSrcE,
   input  logic              TrapReq,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              TrapRedirect,
   output logic              LongBusy,
   output logic              LongDone,
   output logic [REG_AW-1:0] LongRd
);

   trap_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             long_busy;
   logic [REG_AW-1:0] long_rd;
   logic             long_done;
   logic             load_stall;
   logic             long_stall;
   logic             csr_stall;
   logic             hold;

   hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .rs          (Rs1E),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .sel         (ForwardAE)
   );

   hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .rs          (Rs2E),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .sel         (ForwardBE)
   );

   // long result becomes valid on the last occupied cycle
   assign long_done = long_busy && (cnt == CNT_W'(1));

   // hazard detection; LongRd of x0 never creates a register dependency
   always_comb begin
      load_stall = (ResultSrcE == LOAD_SRC) && (RdE != '0) &&
                   ((UseRs1D && (Rs1D == RdE)) || (UseRs2D && (Rs2D == RdE)));
      long_stall = long_busy &&
                   (LongOpD ||
                    ((long_rd != '0) &&
                     ((UseRs1D   && (Rs1D == long_rd)) ||
                      (UseRs2D   && (Rs2D == long_rd)) ||
                      (RegWriteD && (RdD  == long_rd)))));
      csr_stall  = CsrD && (CsrWrE || CsrWrM);
      hold       = load_stall || long_stall || csr_stall;
   end

   // trap FSM and long-op scoreboard; a long op in E is dropped while flushing
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         long_busy <= 1'b0;
         cnt       <= '0;
         long_rd   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (TrapReq)
                  state <= long_busy ? ST_DRAIN : ST_FLUSH;
            end
            ST_DRAIN: begin
               if (long_done || !long_busy)
                  state <= ST_FLUSH;
            end
            ST_FLUSH: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase

         if (LongOpE && (state != ST_FLUSH)) begin
            long_busy <= 1'b1;
            long_rd   <= RdE;
            cnt       <= CNT_W'(LONG_LAT);
         end else if (long_busy) begin
            cnt <= cnt - CNT_W'(1);
            if (long_done)
               long_busy <= 1'b0;
         end
      end
   end

   // pipeline controls, priority FLUSH > DRAIN > taken branch > hold
   always_comb begin
      StallF       = 1'b0;
      StallD       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      FlushM       = 1'b0;
      TrapRedirect = 1'b0;
      case (state)
         ST_FLUSH: begin
            FlushD       = 1'b1;
            FlushE       = 1'b1;
            FlushM       = 1'b1;
            TrapRedirect = 1'b1;
         end
         ST_DRAIN: begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
         default: begin
            if (PCSrcE) begin
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else if (hold) begin
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end
         end
      endcase
   end

   assign LongBusy = long_busy;
   assign LongDone = long_done;
   assign LongRd   = long_rd;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expected control vectors are queued
// as stimulus is applied and compared against the DUT before the next edge.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       UseRs1D, UseRs2D, RegWriteD, LongOpD, CsrD;
   logic [1:0] ResultSrcE;
   logic       LongOpE, CsrWrE, RegWriteM, RegWriteW, CsrWrM, PCSrcE, TrapReq;
   logic       StallF, StallD, FlushD, FlushE, FlushM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       TrapRedirect, LongBusy, LongDone;
   logic [4:0] LongRd;

   // {StallF,StallD,FlushD,FlushE,FlushM}
   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] HOLD = 5'b11010;
   localparam logic [4:0] BRF  = 5'b00110;
   localparam logic [4:0] FLS  = 5'b00111;

   int n_chk  = 0;
   int n_fail = 0;
   string        q_tag[$];
   logic [16:0]  q_exp[$];
   logic [16:0]  obs;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RegWriteD(RegWriteD),
      .LongOpD(LongOpD), .CsrD(CsrD),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
      .LongOpE(LongOpE), .CsrWrE(CsrWrE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .CsrWrM(CsrWrM), .PCSrcE(PCSrcE), .TrapReq(TrapReq),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .TrapRedirect(TrapRedirect), .LongBusy(LongBusy), .LongDone(LongDone),
      .LongRd(LongRd)
   );

   assign obs = {StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
                 TrapRedirect, LongBusy, LongDone, LongRd};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] ex(input logic [4:0] ctl, input logic [1:0] fa,
                                      input logic [1:0] fb, input logic tr,
                                      input logic lb, input logic ld,
                                      input logic [4:0] lrd);
      return {ctl, fa, fb, tr, lb, ld, lrd};
   endfunction

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (SF SD FD FE FM FA FB TR LB LD LRD)",
                  tag, got, exp);
      end
   endtask

   // inputs are set just after a falling edge; outputs compared 2ns later
   task automatic cyc(input string tag, input logic [16:0] e);
      q_tag.push_back(tag);
      q_exp.push_back(e);
      #2;
      if (q_exp.size() != 0)
         chk(q_tag.pop_front(), obs, q_exp.pop_front());
      @(negedge clk);
   endtask

   task automatic clr_in();
      Rs1D = 0; Rs2D = 0; RdD = 0; UseRs1D = 0; UseRs2D = 0; RegWriteD = 0;
      LongOpD = 0; CsrD = 0; Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 0;
      LongOpE = 0; CsrWrE = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
      CsrWrM = 0; PCSrcE = 0; TrapReq = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      clr_in();
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc("reset", ex(NONE, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;

      // load-use
      ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; UseRs1D = 1; RdD = 6; RegWriteD = 1;
      cyc("load_use_rs1", ex(HOLD, 0, 0, 0, 0, 0, 0));
      UseRs1D = 0;
      cyc("load_unused_src", ex(NONE, 0, 0, 0, 0, 0, 0));
      Rs1D = 1; Rs2D = 5; UseRs2D = 1;
      cyc("load_use_rs2", ex(HOLD, 0, 0, 0, 0, 0, 0));
      ResultSrcE = 2'b00;
      cyc("alu_no_stall", ex(NONE, 0, 0, 0, 0, 0, 0));
      ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
      cyc("load_rd_x0", ex(NONE, 0, 0, 0, 0, 0, 0));

      // forwarding
      clr_in();
      RdM = 7; RdW = 7; Rs1E = 7; RegWriteM = 1; RegWriteW = 1;
      cyc("fwd_m_wins", ex(NONE, 2'b10, 2'b00, 0, 0, 0, 0));
      Rs2E = 7;
      cyc("fwd_both_m", ex(NONE, 2'b10, 2'b10, 0, 0, 0, 0));
      RegWriteM = 0;
      cyc("fwd_w_only", ex(NONE, 2'b01, 2'b01, 0, 0, 0, 0));
      RegWriteM = 1; RdM = 3; Rs1E = 0; Rs2E = 3;
      cyc("fwd_b_m_a_x0", ex(NONE, 2'b00, 2'b10, 0, 0, 0, 0));
      RdM = 0; RdW = 0;
      cyc("fwd_x0_match", ex(NONE, 2'b00, 2'b00, 0, 0, 0, 0));

      // CSR serialisation
      clr_in();
      CsrD = 1; CsrWrE = 1;
      cyc("csr_wr_e", ex(HOLD, 0, 0, 0, 0, 0, 0));
      CsrWrE = 0; CsrWrM = 1;
      cyc("csr_wr_m", ex(HOLD, 0, 0, 0, 0, 0, 0));
      CsrWrM = 0;
      cyc("csr_clear", ex(NONE, 0, 0, 0, 0, 0, 0));
      CsrD = 0; CsrWrE = 1;
      cyc("csr_no_d", ex(NONE, 0, 0, 0, 0, 0, 0));

      // taken branch
      clr_in();
      PCSrcE = 1;
      cyc("branch", ex(BRF, 0, 0, 0, 0, 0, 0));
      CsrD = 1; CsrWrE = 1;
      cyc("branch_over_hold", ex(BRF, 0, 0, 0, 0, 0, 0));

      // long op with RAW dependent in D
      clr_in();
      LongOpE = 1; RdE = 9;
      cyc("div_issue", ex(NONE, 0, 0, 0, 0, 0, 0));
      clr_in();
      Rs1D = 9; UseRs1D = 1; RdD = 3; RegWriteD = 1;
      for (int k = 1; k <= 8; k++)
         cyc($sformatf("div_raw_%0d", k), ex(HOLD, 0, 0, 0, 1, (k == 8), 9));
      clr_in();
      cyc("div_retired", ex(NONE, 0, 0, 0, 0, 0, 9));

      // second long op in D behind a long op
      LongOpE = 1; RdE = 9;
      cyc("div2_issue", ex(NONE, 0, 0, 0, 0, 0, 9));
      clr_in();
      LongOpD = 1; RdD = 10; RegWriteD = 1;
      for (int k = 1; k <= 8; k++)
         cyc($sformatf("div_longd_%0d", k), ex(HOLD, 0, 0, 0, 1, (k == 8), 9));
      cyc("div_longd_go", ex(NONE, 0, 0, 0, 0, 0, 9));

      // long op to x0: no register dependency
      clr_in();
      LongOpE = 1; RdE = 0;
      cyc("div_x0_issue", ex(NONE, 0, 0, 0, 0, 0, 9));
      clr_in();
      UseRs1D = 1; RegWriteD = 1;
      for (int k = 1; k <= 8; k++)
         cyc($sformatf("div_x0_%0d", k), ex(NONE, 0, 0, 0, 1, (k == 8), 0));

      // WAW and rs2 dependencies
      clr_in();
      LongOpE = 1; RdE = 12;
      cyc("div_waw_issue", ex(NONE, 0, 0, 0, 0, 0, 0));
      clr_in();
      RegWriteD = 1; RdD = 12;
      cyc("div_waw", ex(HOLD, 0, 0, 0, 1, 0, 12));
      clr_in();
      UseRs2D = 1; Rs2D = 12;
      cyc("div_rs2", ex(HOLD, 0, 0, 0, 1, 0, 12));
      clr_in();
      for (int k = 3; k <= 8; k++)
         cyc($sformatf("div_indep_%0d", k), ex(NONE, 0, 0, 0, 1, (k == 8), 12));

      // trap while long op in flight: DRAIN then FLUSH
      LongOpE = 1; RdE = 4;
      cyc("trap_div_issue", ex(NONE, 0, 0, 0, 0, 0, 12));
      clr_in();
      for (int k = 1; k <= 4; k++)
         cyc($sformatf("trap_pre_%0d", k), ex(NONE, 0, 0, 0, 1, 0, 4));
      TrapReq = 1;
      cyc("trap_req_idle", ex(NONE, 0, 0, 0, 1, 0, 4));
      cyc("drain_1", ex(HOLD, 0, 0, 0, 1, 0, 4));
      PCSrcE = 1;
      cyc("drain_2_branch", ex(HOLD, 0, 0, 0, 1, 0, 4));
      PCSrcE = 0;
      cyc("drain_3_done", ex(HOLD, 0, 0, 0, 1, 1, 4));
      TrapReq = 0; PCSrcE = 1; CsrD = 1; CsrWrE = 1;
      cyc("flush", ex(FLS, 0, 0, 1, 0, 0, 4));
      clr_in();
      cyc("after_flush", ex(NONE, 0, 0, 0, 0, 0, 4));

      // trap with nothing in flight; long op in E during FLUSH is dropped
      TrapReq = 1;
      cyc("trap_idle_req", ex(NONE, 0, 0, 0, 0, 0, 4));
      TrapReq = 0; LongOpE = 1; RdE = 15;
      cyc("trap_idle_flush", ex(FLS, 0, 0, 1, 0, 0, 4));
      clr_in();
      cyc("flush_drops_long", ex(NONE, 0, 0, 0, 0, 0, 4));

      // reset in DRAIN with cnt=4
      LongOpE = 1; RdE = 6;
      cyc("rst_div_issue", ex(NONE, 0, 0, 0, 0, 0, 4));
      clr_in();
      cyc("rst_cnt8", ex(NONE, 0, 0, 0, 1, 0, 6));
      TrapReq = 1;
      cyc("rst_trap_cnt7", ex(NONE, 0, 0, 0, 1, 0, 6));
      cyc("rst_drain_cnt6", ex(HOLD, 0, 0, 0, 1, 0, 6));
      cyc("rst_drain_cnt5", ex(HOLD, 0, 0, 0, 1, 0, 6));
      rst = 1;
      cyc("rst_drain_cnt4", ex(HOLD, 0, 0, 0, 1, 0, 6));
      rst = 0; clr_in();
      cyc("post_reset", ex(NONE, 0, 0, 0, 0, 0, 0));
      cyc("post_reset_idle", ex(NONE, 0, 0, 0, 0, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
